request_scheduler: RTL and testbench



---
 rtl/request_scheduler.sv | 228 ++++++++++++++++++++++
 tb/tb_request_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/request_scheduler.sv
// DRAM request scheduler: queues cache-miss requests and issues ACT/RD/WR/PRE with per-bank timing.
// Define REQ_SCHED_FRFCFS_EN for first-ready FCFS; the default build is strict FCFS.
module request_scheduler #(
    parameter int unsigned A                  = 8,
    parameter int unsigned B                  = 64,
    parameter int unsigned C                  = 16384,
    parameter int unsigned BUS_WIDTH          = 16,
    parameter int unsigned BANK_GROUPS        = 8,
    parameter int unsigned BANKS_PER_GROUP    = 8,
    parameter int unsigned ROW_BITS           = 8,
    parameter int unsigned COL_BITS           = 4,
    parameter int unsigned QUEUE_SIZE         = 16,
    parameter int unsigned ACTIVATION_LATENCY = 8,
    parameter int unsigned PRECHARGE_LATENCY  = 5,
    parameter int unsigned BANKS              = 64
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic [$clog2(BANK_GROUPS)-1:0]     bank_group_in,
    input  logic [$clog2(BANKS_PER_GROUP)-1:0] bank_in,
    input  logic [ROW_BITS-1:0]                row_in,
    input  logic [COL_BITS-1:0]                col_in,
    input  logic                               valid_in,
    input  logic                               write_in,
    input  logic [63:0]                        val_in,
    input  logic                               cmd_ready,
    output logic [$clog2(BANK_GROUPS)-1:0]     bank_group_out,
    output logic [$clog2(BANKS_PER_GROUP)-1:0] bank_out,
    output logic [ROW_BITS-1:0]                row_out,
    output logic [COL_BITS-1:0]                col_out,
    output logic [63:0]                        val_out,
    output logic [2:0]                         cmd_out,
    output logic                               valid_out
);
    localparam int unsigned BG_W    = $clog2(BANK_GROUPS);
    localparam int unsigned BK_W    = $clog2(BANKS_PER_GROUP);
    localparam int unsigned BI_W    = $clog2(BANKS);
    localparam int unsigned QI_W    = $clog2(QUEUE_SIZE);
    localparam int unsigned QC_W    = $clog2(QUEUE_SIZE + 1);
    localparam int unsigned MAX_LAT = (ACTIVATION_LATENCY > PRECHARGE_LATENCY) ?
                                      ACTIVATION_LATENCY : PRECHARGE_LATENCY;
    localparam int unsigned TM_W    = $clog2(MAX_LAT + 1);

    if (BANKS != BANK_GROUPS * BANKS_PER_GROUP || A == 0 || B == 0 || C == 0 ||
        BUS_WIDTH == 0) begin : g_bad_cfg
        $error("request_scheduler: inconsistent configuration");
    end

    typedef enum logic [2:0] {
        CmdNop = 3'b000,
        CmdAct = 3'b001,
        CmdRd  = 3'b010,
        CmdWr  = 3'b011,
        CmdPre = 3'b100
    } cmd_e;

    typedef struct packed {
        logic [BG_W-1:0]     bg;
        logic [BK_W-1:0]     bk;
        logic [ROW_BITS-1:0] row;
        logic [COL_BITS-1:0] col;
        logic                wr;
        logic [63:0]         val;
    } req_t;

    function automatic logic [BI_W-1:0] bank_of(input req_t r);
        return BI_W'(r.bg) * BI_W'(BANKS_PER_GROUP) + BI_W'(r.bk);
    endfunction

    req_t                q_q [QUEUE_SIZE];
    req_t                q_d [QUEUE_SIZE];
    logic [QC_W-1:0]     cnt_q, cnt_d;
    logic [BANKS-1:0]    open_q, open_d;
    logic [ROW_BITS-1:0] orow_q [BANKS];
    logic [ROW_BITS-1:0] orow_d [BANKS];
    logic [TM_W-1:0]     tmr_q [BANKS];
    logic [TM_W-1:0]     tmr_d [BANKS];

    logic                vout_q, vout_d;
    cmd_e                cmd_q, cmd_d;
    logic [BG_W-1:0]     bg_q, bg_d;
    logic [BK_W-1:0]     bk_q, bk_d;
    logic [ROW_BITS-1:0] row_q, row_d;
    logic [COL_BITS-1:0] col_q, col_d;
    logic [63:0]         val_q, val_d;

    logic                sel_vld;
    logic [QI_W-1:0]     sel_idx;
    req_t                cur;
    logic [BI_W-1:0]     cur_bank;
    logic                pop, push;
    req_t                in_req;

    assign in_req = '{bg: bank_group_in, bk: bank_in, row: row_in, col: col_in,
                      wr: write_in, val: val_in};

`ifdef REQ_SCHED_FRFCFS_EN
    always_comb begin : sel_frfcfs
        logic            hit_vld, rdy_vld;
        logic [QI_W-1:0] hit_idx, rdy_idx;
        hit_vld = 1'b0;
        rdy_vld = 1'b0;
        hit_idx = '0;
        rdy_idx = '0;
        // Scan youngest to oldest so the oldest qualifying entry wins.
        for (int i = QUEUE_SIZE - 1; i >= 0; i--) begin
            if ((QC_W'(i) < cnt_q) && (tmr_q[bank_of(q_q[i])] == '0)) begin
                rdy_vld = 1'b1;
                rdy_idx = QI_W'(i);
                if (open_q[bank_of(q_q[i])] && (orow_q[bank_of(q_q[i])] == q_q[i].row)) begin
                    hit_vld = 1'b1;
                    hit_idx = QI_W'(i);
                end
            end
        end
        sel_vld = hit_vld | rdy_vld;
        sel_idx = hit_vld ? hit_idx : rdy_idx;
    end
`else
    always_comb begin
        sel_idx = '0;
        sel_vld = (cnt_q != '0) && (tmr_q[bank_of(q_q[0])] == '0);
    end
`endif

    always_comb begin
        q_d    = q_q;
        open_d = open_q;
        orow_d = orow_q;
        for (int b = 0; b < BANKS; b++) begin
            tmr_d[b] = (tmr_q[b] != '0) ? tmr_q[b] - 1'b1 : '0;
        end
        vout_d   = 1'b0;
        cmd_d    = CmdNop;
        bg_d     = bg_q;
        bk_d     = bk_q;
        row_d    = row_q;
        col_d    = col_q;
        val_d    = val_q;
        pop      = 1'b0;
        cur      = q_q[sel_idx];
        cur_bank = bank_of(cur);

        if (cmd_ready && sel_vld) begin
            vout_d = 1'b1;
            bg_d   = cur.bg;
            bk_d   = cur.bk;
            row_d  = cur.row;
            col_d  = cur.col;
            if (open_q[cur_bank] && (orow_q[cur_bank] == cur.row)) begin
                cmd_d = cur.wr ? CmdWr : CmdRd;
                if (cur.wr) begin
                    val_d = cur.val;
                end
                pop = 1'b1;
            end else if (!open_q[cur_bank]) begin
                cmd_d            = CmdAct;
                open_d[cur_bank] = 1'b1;
                orow_d[cur_bank] = cur.row;
                // Loaded one short so the bank's next command lands exactly LATENCY edges later.
                tmr_d[cur_bank]  = TM_W'(ACTIVATION_LATENCY - 1);
            end else begin
                cmd_d            = CmdPre;
                open_d[cur_bank] = 1'b0;
                tmr_d[cur_bank]  = TM_W'(PRECHARGE_LATENCY - 1);
            end
        end

        if (pop) begin
            for (int i = 0; i < QUEUE_SIZE - 1; i++) begin
                if (QI_W'(i) >= sel_idx) begin
                    q_d[i] = q_q[i + 1];
                end
            end
        end

        // Fullness is judged on the pre-pop occupancy.
        push = valid_in && (cnt_q < QC_W'(QUEUE_SIZE));
        if (push) begin
            q_d[QI_W'(cnt_q - QC_W'(pop))] = in_req;
        end
        cnt_d = cnt_q + QC_W'(push) - QC_W'(pop);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q  <= '0;
            open_q <= '0;
            for (int b = 0; b < BANKS; b++) begin
                orow_q[b] <= '0;
                tmr_q[b]  <= '0;
            end
            vout_q <= 1'b0;
            cmd_q  <= CmdNop;
            bg_q   <= '0;
            bk_q   <= '0;
            row_q  <= '0;
            col_q  <= '0;
            val_q  <= '0;
        end else begin
            q_d_copy : for (int i = 0; i < QUEUE_SIZE; i++) begin
                q_q[i] <= q_d[i];
            end
            cnt_q  <= cnt_d;
            open_q <= open_d;
            for (int b = 0; b < BANKS; b++) begin
                orow_q[b] <= orow_d[b];
                tmr_q[b]  <= tmr_d[b];
            end
            vout_q <= vout_d;
            cmd_q  <= cmd_d;
            bg_q   <= bg_d;
            bk_q   <= bk_d;
            row_q  <= row_d;
            col_q  <= col_d;
            val_q  <= val_d;
        end
    end

    assign valid_out      = vout_q;
    assign cmd_out        = cmd_q;
    assign bank_group_out = bg_q;
    assign bank_out       = bk_q;
    assign row_out        = row_q;
    assign col_out        = col_q;
    assign val_out        = val_q;

endmodule

// File: tb/tb_request_scheduler.sv
// Self-checking bench for request_scheduler (default strict-FCFS build): vector table,
// hand-written stall/full/reset sequences, and a command scoreboard checked at negedge.
module tb_request_scheduler;
    localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, PRE = 3'd4;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [2:0]  bank_group_in = '0;
    logic [2:0]  bank_in = '0;
    logic [7:0]  row_in = '0;
    logic [3:0]  col_in = '0;
    logic        valid_in = 1'b0;
    logic        write_in = 1'b0;
    logic [63:0] val_in = '0;
    logic        cmd_ready = 1'b1;
    logic [2:0]  bank_group_out;
    logic [2:0]  bank_out;
    logic [7:0]  row_out;
    logic [3:0]  col_out;
    logic [63:0] val_out;
    logic [2:0]  cmd_out;
    logic        valid_out;

    request_scheduler dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .bank_group_in  (bank_group_in),
        .bank_in        (bank_in),
        .row_in         (row_in),
        .col_in         (col_in),
        .valid_in       (valid_in),
        .write_in       (write_in),
        .val_in         (val_in),
        .cmd_ready      (cmd_ready),
        .bank_group_out (bank_group_out),
        .bank_out       (bank_out),
        .row_out        (row_out),
        .col_out        (col_out),
        .val_out        (val_out),
        .cmd_out        (cmd_out),
        .valid_out      (valid_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [2:0]  cmd;
        logic [2:0]  bg;
        logic [2:0]  bk;
        logic [7:0]  row;
        logic [3:0]  col;
        logic [63:0] val;
        logic [3:0]  gap;   // cycles since previous command; 0 = unchecked
    } exp_t;

    typedef struct packed {
        logic [2:0]  bg;
        logic [2:0]  bk;
        logic [7:0]  row;
        logic [3:0]  col;
        logic        wr;
        logic [63:0] val;
        logic        b2b;
        logic [2:0]  c0, c1, c2;
        logic [3:0]  g0, g1, g2;
    } vec_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    int   n_valid = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_exp(input logic [2:0] c, input logic [2:0] bg,
                                     input logic [2:0] bk, input logic [7:0] row,
                                     input logic [3:0] col, input logic [63:0] val,
                                     input logic [3:0] gap);
        exp_t e;
        e = '{cmd: c, bg: bg, bk: bk, row: row, col: col, val: val, gap: gap};
        sb.push_back(e);
    endfunction

    always @(negedge clk_in) begin
        exp_t e;
        cyc++;
        if (!rst_in) begin
            if (valid_out) begin
                n_valid++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_cmd: got cmd %0d bg %0d bank %0d col %0h, expected none (cycle %0d)",
                             cmd_out, bank_group_out, bank_out, col_out, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("cmd_out", 64'(cmd_out), 64'(e.cmd));
                    chk("bank_group_out", 64'(bank_group_out), 64'(e.bg));
                    chk("bank_out", 64'(bank_out), 64'(e.bk));
                    if (e.cmd == ACT) chk("row_out", 64'(row_out), 64'(e.row));
                    if (e.cmd == RD || e.cmd == WR) chk("col_out", 64'(col_out), 64'(e.col));
                    if (e.cmd == WR) chk("val_out", val_out, e.val);
                    if (e.gap != 0) chk("cmd_gap", 64'(cyc - last_cyc), 64'(e.gap));
                end
                last_cyc = cyc;
            end else begin
                chk("idle_cmd_nop", 64'(cmd_out), 64'(NOP));
            end
        end
    end

    task automatic drive(input logic [2:0] bg, input logic [2:0] bk, input logic [7:0] row,
                         input logic [3:0] col, input logic wr, input logic [63:0] val);
        bank_group_in = bg;
        bank_in       = bk;
        row_in        = row;
        col_in        = col;
        write_in      = wr;
        val_in        = val;
        valid_in      = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic wait_sb(input int left, input int budget);
        int k = 0;
        while (sb.size() > left && k < budget) begin
            @(negedge clk_in);
            #1;
            k++;
        end
        if (sb.size() > left) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_timeout: got %0d pending commands, expected %0d", sb.size(), left);
            sb.delete();
        end
    endtask

    task automatic drain(input int budget);
        wait_sb(0, budget);
        repeat (10) @(negedge clk_in);
    endtask

    task automatic chk_reset_outputs();
        chk("reset_valid_out", 64'(valid_out), 64'd0);
        chk("reset_cmd_out", 64'(cmd_out), 64'd0);
        chk("reset_bank_group_out", 64'(bank_group_out), 64'd0);
        chk("reset_bank_out", 64'(bank_out), 64'd0);
        chk("reset_row_out", 64'(row_out), 64'd0);
        chk("reset_col_out", 64'(col_out), 64'd0);
        chk("reset_val_out", val_out, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t vecs [9];
        int   base;

        vecs[0] = '{3'd3, 3'd2, 8'h55, 4'hA, 1'b0, 64'h0, 1'b0, ACT, RD, NOP, 4'd0, 4'd8, 4'd0};
        vecs[1] = '{3'd2, 3'd1, 8'hF0, 4'h6, 1'b0, 64'h0, 1'b1, ACT, RD, NOP, 4'd0, 4'd8, 4'd0};
        vecs[2] = '{3'd2, 3'd1, 8'hF0, 4'h1, 1'b0, 64'h0, 1'b0, RD, NOP, NOP, 4'd1, 4'd0, 4'd0};
        vecs[3] = '{3'd2, 3'd1, 8'h0F, 4'h8, 1'b0, 64'h0, 1'b0, PRE, ACT, RD, 4'd0, 4'd5, 4'd8};
        vecs[4] = '{3'd7, 3'd7, 8'h00, 4'hF, 1'b1, 64'h0123456789ABCDEF, 1'b0,
                    ACT, WR, NOP, 4'd0, 4'd8, 4'd0};
        vecs[5] = '{3'd0, 3'd0, 8'h00, 4'h0, 1'b0, 64'h0, 1'b0, ACT, RD, NOP, 4'd0, 4'd8, 4'd0};
        vecs[6] = '{3'd0, 3'd0, 8'h00, 4'h5, 1'b1, 64'hFFFF_0000_FFFF_0000, 1'b0,
                    WR, NOP, NOP, 4'd0, 4'd0, 4'd0};
        vecs[7] = '{3'd3, 3'd2, 8'h55, 4'hC, 1'b0, 64'h0, 1'b0, RD, NOP, NOP, 4'd0, 4'd0, 4'd0};
        vecs[8] = '{3'd3, 3'd2, 8'hAA, 4'h3, 1'b0, 64'h0, 1'b0, PRE, ACT, RD, 4'd0, 4'd5, 4'd8};

        // Reset for one edge.
        @(negedge clk_in);
        chk_reset_outputs();
        rst_in = 1'b0;
        repeat (10) @(negedge clk_in);
        #1;
        chk("empty_after_reset", 64'(n_valid), 64'd0);

        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            if (v.c0 != NOP) push_exp(v.c0, v.bg, v.bk, v.row, v.col, v.val, v.g0);
            if (v.c1 != NOP) push_exp(v.c1, v.bg, v.bk, v.row, v.col, v.val, v.g1);
            if (v.c2 != NOP) push_exp(v.c2, v.bg, v.bk, v.row, v.col, v.val, v.g2);
            drive(v.bg, v.bk, v.row, v.col, v.wr, v.val);
            if (!v.b2b) begin
                valid_in = 1'b0;
                drain(100);
            end
        end

        // Write held off by cmd_ready=0, then timer must keep counting through a ready gap.
        cmd_ready = 1'b0;
        #1;
        base = n_valid;
        push_exp(ACT, 3'd1, 3'd1, 8'hFF, 4'h3, 64'h0, 4'd0);
        push_exp(WR, 3'd1, 3'd1, 8'hFF, 4'h3, 64'hA5A5A5A5A5A5A5A5, 4'd8);
        @(negedge clk_in);
        drive(3'd1, 3'd1, 8'hFF, 4'h3, 1'b1, 64'hA5A5A5A5A5A5A5A5);
        valid_in = 1'b0;
        repeat (20) @(negedge clk_in);
        #1;
        chk("stall_no_cmd", 64'(n_valid - base), 64'd0);
        cmd_ready = 1'b1;
        wait_sb(1, 20);
        cmd_ready = 1'b0;
        repeat (4) @(negedge clk_in);
        cmd_ready = 1'b1;
        drain(40);

        // Fill the queue past capacity with row hits; the 17th request must be dropped.
        cmd_ready = 1'b0;
        #1;
        base = n_valid;
        @(negedge clk_in);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) begin
                push_exp((i % 2 == 0) ? WR : RD, 3'd1, 3'd1, 8'hFF, i[3:0], {16{i[3:0]}},
                         (i == 0) ? 4'd0 : 4'd1);
            end
            drive(3'd1, 3'd1, 8'hFF, i[3:0], (i % 2 == 0), {16{i[3:0]}});
        end
        valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        #1;
        chk("full_stall_no_cmd", 64'(n_valid - base), 64'd0);
        cmd_ready = 1'b1;
        drain(60);
        #1;
        chk("full_cmd_count", 64'(n_valid - base), 64'd16);

        // Reset mid-operation: queued read discarded and bank closed again.
        push_exp(ACT, 3'd5, 3'd4, 8'h33, 4'h2, 64'h0, 4'd0);
        @(negedge clk_in);
        drive(3'd5, 3'd4, 8'h33, 4'h2, 1'b0, 64'h0);
        valid_in = 1'b0;
        wait_sb(0, 10);
        rst_in = 1'b1;
        @(negedge clk_in);
        #1;
        chk_reset_outputs();
        rst_in = 1'b0;
        base = n_valid;
        repeat (12) @(negedge clk_in);
        #1;
        chk("reset_discard_queue", 64'(n_valid - base), 64'd0);
        push_exp(ACT, 3'd5, 3'd4, 8'h33, 4'h2, 64'h0, 4'd0);
        push_exp(RD, 3'd5, 3'd4, 8'h33, 4'h2, 64'h0, 4'd8);
        @(negedge clk_in);
        drive(3'd5, 3'd4, 8'h33, 4'h2, 1'b0, 64'h0);
        valid_in = 1'b0;
        drain(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
